// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG encoder block-reordering path.
package jpeg_pkg;

  localparam int BLK_DIM  = 8;
  localparam int BLK_SIZE = BLK_DIM * BLK_DIM;
  localparam int PIX_W    = 24;

  // Packed {Y,U,V} pixel, 8 bits per component
  typedef logic [PIX_W-1:0] yuv_pix_t;

  // Reader FSM: wait for a full bank, then walk it block by block
  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

endpackage

// File: rtl/block_bank_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with enable.
// Holds both line-store banks; the bank is selected by the upper address range.
module block_bank_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output holds while re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-8x8-block reorder buffer. Pixels arrive in raster order and are
// stored 8 lines at a time in a ping-pong line store; each full band is then
// re-emitted as blocks in block-raster order through a 2-stage read pipeline.
module raster_to_block #(
  parameter int PIXEL_BITWIDTH = 24,
  parameter int IMG_WIDTH      = 640,
  parameter int BLK_DIM        = 8
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [PIXEL_BITWIDTH-1:0] i_tdata,
  input  logic                      i_tlast,
  input  logic                      i_tuser,
  input  logic                      i_tvalid,
  output logic                      o_wait,
  input  logic                      i_wait,
  output logic [PIXEL_BITWIDTH-1:0] o_tdata,
  output logic                      o_tlast,
  output logic                      o_tuser,
  output logic                      o_tvalid,
  output logic                      o_err
);
  import jpeg_pkg::*;

  localparam int COL_W      = $clog2(IMG_WIDTH);
  localparam int ROW_W      = $clog2(BLK_DIM);
  localparam int BX_N       = IMG_WIDTH / BLK_DIM;
  localparam int BX_W       = (BX_N > 1) ? $clog2(BX_N) : 1;
  localparam int BANK_DEPTH = BLK_DIM * IMG_WIDTH;
  localparam int AW         = $clog2(2 * BANK_DEPTH);

  // Write side state
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             wr_bank;
  logic [1:0]       full;
  logic [1:0]       sof_pending;

  logic             accept, col_end, row_end, band_done;
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic [AW-1:0]    wr_addr;
  logic [1:0]       full_nxt;
  logic             wr_bank_nxt;

  // Read side state
  rd_state_t        state, state_nxt;
  logic             rd_bank;
  logic [BX_W-1:0]  bx;
  logic [ROW_W-1:0] r, c;
  logic             stall, issue_p0, last_addr, rd_clear;
  logic [AW-1:0]    rd_addr_p0;

  logic                      vld_p1, last_p1, user_p1;
  logic [PIXEL_BITWIDTH-1:0] pix_p1;

  // Write addressing; i_tuser restarts the band at row 0, col 0
  always_comb begin
    accept    = i_tvalid && !o_wait;
    eff_col   = i_tuser ? '0 : col;
    eff_row   = i_tuser ? '0 : row;
    col_end   = (eff_col == COL_W'(IMG_WIDTH - 1));
    row_end   = (eff_row == ROW_W'(BLK_DIM - 1));
    band_done = accept && i_tlast && row_end;
    wr_addr   = AW'(wr_bank) * AW'(BANK_DEPTH) + AW'(eff_row) * AW'(IMG_WIDTH)
              + AW'(eff_col);
  end

  // Bank flags after this cycle's fill and drain events (always distinct banks)
  always_comb begin
    full_nxt = full;
    if (band_done) full_nxt[wr_bank] = 1'b1;
    if (rd_clear)  full_nxt[rd_bank] = 1'b0;
    wr_bank_nxt = wr_bank ^ band_done;
  end

  // Writer counters, bank flags, stall and sticky error
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col         <= '0;
      row         <= '0;
      wr_bank     <= 1'b0;
      full        <= '0;
      sof_pending <= '0;
      o_wait      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      // Look ahead so no beat can land in a bank that just became full
      o_wait  <= full_nxt[wr_bank_nxt];
      if (accept) begin
        if (eff_row == '0 && eff_col == '0) sof_pending[wr_bank] <= i_tuser;
        if (i_tlast) begin
          if (!col_end) o_err <= 1'b1;
          col <= '0;
          row <= row_end ? '0 : eff_row + ROW_W'(1);
        end else if (col_end) begin
          o_err <= 1'b1;
          col   <= '0;
          row   <= eff_row;
        end else begin
          col <= eff_col + COL_W'(1);
          row <= eff_row;
        end
      end
    end
  end

  // Reader next state; a band completing into rd_bank starts the drain at once
  always_comb begin
    stall      = i_wait;
    issue_p0   = (state == DRAIN) && !stall;
    last_addr  = (bx == BX_W'(BX_N - 1)) && (r == ROW_W'(BLK_DIM - 1))
              && (c == ROW_W'(BLK_DIM - 1));
    rd_clear   = issue_p0 && last_addr;
    rd_addr_p0 = AW'(rd_bank) * AW'(BANK_DEPTH) + AW'(r) * AW'(IMG_WIDTH)
               + AW'(bx) * AW'(BLK_DIM) + AW'(c);
    state_nxt  = state;
    case (state)
      IDLE:    if (full[rd_bank] || (band_done && wr_bank == rd_bank)) state_nxt = DRAIN;
      DRAIN:   if (rd_clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reader state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Block walk counters: c, then r, then bx
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bx      <= '0;
      r       <= '0;
      c       <= '0;
      rd_bank <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == DRAIN) begin
        bx <= '0;
        r  <= '0;
        c  <= '0;
      end else if (issue_p0) begin
        if (c == ROW_W'(BLK_DIM - 1)) begin
          c <= '0;
          if (r == ROW_W'(BLK_DIM - 1)) begin
            r  <= '0;
            bx <= (bx == BX_W'(BX_N - 1)) ? '0 : bx + BX_W'(1);
          end else begin
            r <= r + ROW_W'(1);
          end
        end else begin
          c <= c + ROW_W'(1);
        end
      end
      if (rd_clear) rd_bank <= ~rd_bank;
    end
  end

  block_bank_ram #(
    .DATA_W (PIXEL_BITWIDTH),
    .DEPTH  (2 * BANK_DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (i_tdata),
    .re    (issue_p0),
    .raddr (rd_addr_p0),
    .rdata (pix_p1)
  );

  // ---- p0 -> p1: address issued, RAM word and flags captured ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      user_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1  <= issue_p0;
      last_p1 <= (r == ROW_W'(BLK_DIM - 1)) && (c == ROW_W'(BLK_DIM - 1));
      user_p1 <= sof_pending[rd_bank] && bx == '0 && r == '0 && c == '0;
    end
  end

  // ---- p1 -> p2: output register, frozen while downstream waits ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tuser  <= 1'b0;
      o_tdata  <= '0;
    end else if (!stall) begin
      o_tvalid <= vld_p1;
      o_tlast  <= vld_p1 && last_p1;
      o_tuser  <= vld_p1 && user_p1;
      o_tdata  <= pix_p1;
    end
  end

endmodule
